spike_rate_encoder: RTL



---
 rtl/snn_pkg.sv | 22 ++
 rtl/rate_channel.sv | 66 ++++++
 rtl/spike_rate_encoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the spike rate encoder and its channels.
// Stochastic mode (SPIKE_ENC_STOCHASTIC_EN) uses the LFSR seed and tap mask below.
package snn_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int VAL_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rate_channel.sv
// One encoder channel: stored intensity, phase accumulator and registered spike.
// Build option SPIKE_ENC_STOCHASTIC_EN replaces the accumulator with a compare against a shared random word.
module rate_channel #(
    parameter int VAL_W  = 8,
    parameter int CH_IDX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             write_i,
    input  logic [VAL_W-1:0] wval_i,
`ifdef SPIKE_ENC_STOCHASTIC_EN
    input  logic [VAL_W-1:0] rnd_i,
`endif
    output logic             spike_o
);

    logic [VAL_W-1:0] val_q;
    logic             spike_q;

`ifdef SPIKE_ENC_STOCHASTIC_EN
    // Per-channel scramble so channels sharing one LFSR do not fire in lockstep.
    localparam logic [VAL_W-1:0] MASK = VAL_W'(CH_IDX * 8'h25);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            if (write_i) val_q <= wval_i;
            if (clear_i) begin
                spike_q <= 1'b0;
            end else if (enable_i) begin
                spike_q <= ((rnd_i ^ MASK) < val_q);
            end
        end
    end
`else
    logic [VAL_W-1:0] acc_q;
    logic [VAL_W:0]   sum_d;

    assign sum_d = {1'b0, acc_q} + {1'b0, val_q};

    // The carry out of the accumulator is the spike; over 2**VAL_W updates it fires exactly val times.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q   <= '0;
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            if (write_i) val_q <= wval_i;
            if (clear_i) begin
                acc_q   <= '0;
                spike_q <= 1'b0;
            end else if (enable_i) begin
                acc_q   <= sum_d[VAL_W-1:0];
                spike_q <= sum_d[VAL_W];
            end
        end
    end
`endif

    assign spike_o = spike_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder driving a neuron's presynaptic inputs: IDLE loads values, RUN emits one 2**VAL_W-cycle window.
// Optional macro SPIKE_ENC_STOCHASTIC_EN switches channels to Bernoulli spikes from a shared 16-bit LFSR.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int VAL_W = VAL_W_DEF,
    parameter int CH_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [CH_W-1:0]  load_ch,
    input  logic [VAL_W-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             learn,
    output logic [N_CH-1:0]  spikes
);

    state_t           state_q, state_d;
    logic [VAL_W-1:0] cnt_q, cnt_d;
    logic             ch_clr;
    logic             ch_en;
    logic             wr_en;
    logic [N_CH-1:0]  ch_wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_clr     = 1'b0;
        ch_en      = 1'b0;
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (start) begin
                    state_d = RUN;
                    ch_clr  = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Abort wins over the terminal count.
                if (stop) begin
                    state_d = IDLE;
                    ch_clr  = 1'b1;
                end else begin
                    ch_en = 1'b1;
                    if (cnt_q == '1) state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                ch_clr  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ch_clr  = 1'b1;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ch_clr)     cnt_d = '0;
        else if (ch_en) cnt_d = cnt_q + VAL_W'(1);
    end

    assign learn = busy;
    assign wr_en = load_valid && load_ready;

`ifdef SPIKE_ENC_STOCHASTIC_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == IDLE && start) lfsr_d = LFSR_SEED;
        else if (ch_en)               lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`endif

    // Indices with no matching channel simply complete the handshake without a write.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ch_wr[i] = wr_en && (load_ch == CH_W'(i));

        rate_channel #(
            .VAL_W  (VAL_W),
            .CH_IDX (i)
        ) u_ch (
            .clk      (clk),
            .rst_n    (reset),
            .clear_i  (ch_clr),
            .enable_i (ch_en),
            .write_i  (ch_wr[i]),
            .wval_i   (load_val),
`ifdef SPIKE_ENC_STOCHASTIC_EN
            .rnd_i    (lfsr_q[VAL_W-1:0]),
`endif
            .spike_o  (spikes[i])
        );
    end

endmodule
